// File: rtl/rob_commit_queue.sv
// Reorder buffer commit queue: circular buffer of in-flight instructions,
// dual allocate, dual writeback, branch flush marking and in-order dual commit.

// One ROB slot: status bits plus destination register payload.
module rob_entry #(
  parameter int L_ADDR_WIDTH = 5,
  parameter int P_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc,
  input  logic [L_ADDR_WIDTH-1:0] wr_lreg,
  input  logic [P_ADDR_WIDTH-1:0] wr_preg,
  input  logic [P_ADDR_WIDTH-1:0] wr_ppreg,
  input  logic                    set_done,
  input  logic                    set_flush,
  input  logic                    clear,
  output logic                    valid,
  output logic                    done,
  output logic                    flushed,
  output logic [L_ADDR_WIDTH-1:0] lreg,
  output logic [P_ADDR_WIDTH-1:0] preg,
  output logic [P_ADDR_WIDTH-1:0] ppreg
);
  // Allocation starts a fresh entry; commit retires it; otherwise status bits only accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      done    <= 1'b0;
      flushed <= 1'b0;
      lreg    <= '0;
      preg    <= '0;
      ppreg   <= '0;
    end else if (alloc) begin
      valid   <= 1'b1;
      done    <= 1'b0;
      flushed <= 1'b0;
      lreg    <= wr_lreg;
      preg    <= wr_preg;
      ppreg   <= wr_ppreg;
    end else if (clear) begin
      valid   <= 1'b0;
      done    <= 1'b0;
      flushed <= 1'b0;
    end else if (valid) begin
      if (set_done)  done    <= 1'b1;
      if (set_flush) flushed <= 1'b1;
    end
  end
endmodule

module rob_commit_queue #(
  parameter int ROB_INDEX_BITS = 3,
  parameter int P_ADDR_WIDTH   = 5,
  parameter int L_ADDR_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_1,
  input  logic                      req_valid_2,
  input  logic [L_ADDR_WIDTH-1:0]   req_lreg_1,
  input  logic [L_ADDR_WIDTH-1:0]   req_lreg_2,
  input  logic [P_ADDR_WIDTH-1:0]   req_preg_1,
  input  logic [P_ADDR_WIDTH-1:0]   req_preg_2,
  input  logic [P_ADDR_WIDTH-1:0]   req_ppreg_1,
  input  logic [P_ADDR_WIDTH-1:0]   req_ppreg_2,
  output logic [ROB_INDEX_BITS-1:0] ticket,
  output logic                      is_full,
  output logic                      two_empty,
  output logic                      overflow_err,
  input  logic                      wb_valid_1,
  input  logic                      wb_valid_2,
  input  logic [ROB_INDEX_BITS-1:0] wb_ticket_1,
  input  logic [ROB_INDEX_BITS-1:0] wb_ticket_2,
  input  logic                      flush_valid,
  input  logic [ROB_INDEX_BITS-1:0] flush_ticket,
  output logic                      commit_valid_1,
  output logic                      commit_valid_2,
  output logic [L_ADDR_WIDTH-1:0]   commit_ldst_1,
  output logic [L_ADDR_WIDTH-1:0]   commit_ldst_2,
  output logic [P_ADDR_WIDTH-1:0]   commit_pdst_1,
  output logic [P_ADDR_WIDTH-1:0]   commit_pdst_2,
  output logic [P_ADDR_WIDTH-1:0]   commit_ppdst_1,
  output logic [P_ADDR_WIDTH-1:0]   commit_ppdst_2,
  output logic                      commit_flushed_1,
  output logic                      commit_flushed_2
);
  localparam int DEPTH = 1 << ROB_INDEX_BITS;
  localparam int CW    = ROB_INDEX_BITS + 1;

  logic [ROB_INDEX_BITS-1:0] head, tail, head1, tail1, fage;
  logic [CW-1:0]             count;
  logic                      alloc1, alloc2;
  logic [1:0]                n_alloc, n_commit;

  logic [DEPTH-1:0]                   ent_v, ent_d, ent_f;
  logic [DEPTH-1:0][L_ADDR_WIDTH-1:0] ent_lreg;
  logic [DEPTH-1:0][P_ADDR_WIDTH-1:0] ent_preg, ent_ppreg;

  assign head1     = head + ROB_INDEX_BITS'(1);
  assign tail1     = tail + ROB_INDEX_BITS'(1);
  assign ticket    = tail;
  assign is_full   = (count == CW'(DEPTH));
  assign two_empty = (count <= CW'(DEPTH - 2));

  // Flush wins over allocation; slot 2 needs room for both so it never skips slot 1.
  assign alloc1   = req_valid_1 & ~is_full & ~flush_valid;
  assign alloc2   = req_valid_2 & two_empty & ~flush_valid;
  assign n_alloc  = {1'b0, alloc1} + {1'b0, alloc2};

  // Commit looks only at registered entry state, so it sees the pre-edge picture.
  assign commit_valid_1 = ent_v[head] & (ent_d[head] | ent_f[head]);
  assign commit_valid_2 = commit_valid_1 & ent_v[head1] & (ent_d[head1] | ent_f[head1]);
  assign n_commit       = {1'b0, commit_valid_1} + {1'b0, commit_valid_2};

  assign commit_ldst_1    = commit_valid_1 ? ent_lreg[head]   : '0;
  assign commit_pdst_1    = commit_valid_1 ? ent_preg[head]   : '0;
  assign commit_ppdst_1   = commit_valid_1 ? ent_ppreg[head]  : '0;
  assign commit_flushed_1 = commit_valid_1 & ent_f[head];
  assign commit_ldst_2    = commit_valid_2 ? ent_lreg[head1]  : '0;
  assign commit_pdst_2    = commit_valid_2 ? ent_preg[head1]  : '0;
  assign commit_ppdst_2   = commit_valid_2 ? ent_ppreg[head1] : '0;
  assign commit_flushed_2 = commit_valid_2 & ent_f[head1];

  // Age relative to head turns "younger than the branch" into a plain compare.
  assign fage = flush_ticket - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam int unsigned II = i;
    localparam logic [ROB_INDEX_BITS-1:0] IDX = ROB_INDEX_BITS'(II);
    logic [ROB_INDEX_BITS-1:0] age;
    logic sel1, sel2;
    assign age  = IDX - head;
    assign sel1 = alloc1 && (tail == IDX);
    assign sel2 = alloc2 && (tail1 == IDX);
    rob_entry #(.L_ADDR_WIDTH(L_ADDR_WIDTH), .P_ADDR_WIDTH(P_ADDR_WIDTH)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .alloc    (sel1 | sel2),
      .wr_lreg  (sel2 ? req_lreg_2  : req_lreg_1),
      .wr_preg  (sel2 ? req_preg_2  : req_preg_1),
      .wr_ppreg (sel2 ? req_ppreg_2 : req_ppreg_1),
      .set_done ((wb_valid_1 && wb_ticket_1 == IDX) || (wb_valid_2 && wb_ticket_2 == IDX)),
      .set_flush(flush_valid && (age > fage)),
      .clear    ((commit_valid_1 && head == IDX) || (commit_valid_2 && head1 == IDX)),
      .valid    (ent_v[i]),
      .done     (ent_d[i]),
      .flushed  (ent_f[i]),
      .lreg     (ent_lreg[i]),
      .preg     (ent_preg[i]),
      .ppreg    (ent_ppreg[i])
    );
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      head  <= head + ROB_INDEX_BITS'(n_commit);
      tail  <= tail + ROB_INDEX_BITS'(n_alloc);
      count <= count + CW'(n_alloc) - CW'(n_commit);
      if ((req_valid_1 && is_full) || (req_valid_2 && !two_empty))
        overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rob_commit_queue.sv
// Randomized + directed bench for rob_commit_queue; a program-order queue
// model predicts commits, a negedge monitor compares whatever the DUT presents.
module tb_rob_commit_queue;
  localparam int RIB = 3, LW = 5, PW = 6, DEPTH = 8;

  logic clk = 0, rst = 1;
  logic req_valid_1 = 0, req_valid_2 = 0;
  logic [LW-1:0] req_lreg_1 = 0, req_lreg_2 = 0;
  logic [PW-1:0] req_preg_1 = 0, req_preg_2 = 0, req_ppreg_1 = 0, req_ppreg_2 = 0;
  logic [RIB-1:0] ticket;
  logic is_full, two_empty, overflow_err;
  logic wb_valid_1 = 0, wb_valid_2 = 0, flush_valid = 0;
  logic [RIB-1:0] wb_ticket_1 = 0, wb_ticket_2 = 0, flush_ticket = 0;
  logic commit_valid_1, commit_valid_2, commit_flushed_1, commit_flushed_2;
  logic [LW-1:0] commit_ldst_1, commit_ldst_2;
  logic [PW-1:0] commit_pdst_1, commit_pdst_2, commit_ppdst_1, commit_ppdst_2;

  always #5 clk = ~clk;

  rob_commit_queue #(.ROB_INDEX_BITS(RIB), .P_ADDR_WIDTH(PW), .L_ADDR_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_1(req_valid_1), .req_valid_2(req_valid_2),
    .req_lreg_1(req_lreg_1), .req_lreg_2(req_lreg_2),
    .req_preg_1(req_preg_1), .req_preg_2(req_preg_2),
    .req_ppreg_1(req_ppreg_1), .req_ppreg_2(req_ppreg_2),
    .ticket(ticket), .is_full(is_full), .two_empty(two_empty), .overflow_err(overflow_err),
    .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2),
    .wb_ticket_1(wb_ticket_1), .wb_ticket_2(wb_ticket_2),
    .flush_valid(flush_valid), .flush_ticket(flush_ticket),
    .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
    .commit_ldst_1(commit_ldst_1), .commit_ldst_2(commit_ldst_2),
    .commit_pdst_1(commit_pdst_1), .commit_pdst_2(commit_pdst_2),
    .commit_ppdst_1(commit_ppdst_1), .commit_ppdst_2(commit_ppdst_2),
    .commit_flushed_1(commit_flushed_1), .commit_flushed_2(commit_flushed_2)
  );

  typedef struct {
    int           tk;
    logic [LW-1:0] l;
    logic [PW-1:0] p, pp;
    bit           d, f;
  } ent_t;

  ent_t mq[$];        // in-flight instructions, oldest first
  int   mt = 0;       // next ticket to hand out
  bit   movf = 0;
  int   errors = 0, checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: status outputs and commit ports against the model, then retire.
  logic [31:0] e1, e2;
  bit ev1, ev2;
  always @(negedge clk) begin
    chk("ticket", ticket, mt);
    chk("is_full", is_full, mq.size() == DEPTH);
    chk("two_empty", two_empty, mq.size() <= DEPTH - 2);
    chk("overflow_err", overflow_err, movf);
    ev1 = 0; ev2 = 0; e1 = 0; e2 = 0;
    if (mq.size() > 0) ev1 = mq[0].d || mq[0].f;
    if (ev1 && mq.size() > 1) ev2 = mq[1].d || mq[1].f;
    if (ev1) e1 = {mq[0].l, mq[0].p, mq[0].pp, mq[0].f};
    if (ev2) e2 = {mq[1].l, mq[1].p, mq[1].pp, mq[1].f};
    chk("commit_valid_1", commit_valid_1, ev1);
    chk("commit_valid_2", commit_valid_2, ev2);
    chk("commit_1", {commit_ldst_1, commit_pdst_1, commit_ppdst_1, commit_flushed_1}, e1);
    chk("commit_2", {commit_ldst_2, commit_pdst_2, commit_ppdst_2, commit_flushed_2}, e2);
    if (ev1) void'(mq.pop_front());
    if (ev2) void'(mq.pop_front());
  end

  task automatic mark_done(int t);
    foreach (mq[k]) if (mq[k].tk == t) mq[k].d = 1;
  endtask

  // Everything after the branch in program order is wrong-path; if the branch
  // itself retired this edge, everything left is younger.
  task automatic mark_flush(int t);
    int idx = -1;
    foreach (mq[k]) if (mq[k].tk == t) idx = k;
    for (int k = idx + 1; k < mq.size(); k++) mq[k].f = 1;
  endtask

  // One clock with the inputs currently driven; model updated at the edge.
  task automatic step();
    int n = mq.size();
    bit a1, a2, ov, w1, w2, f;
    int t1, t2, ft;
    ent_t n1, n2;
    a1 = req_valid_1 && n < DEPTH && !flush_valid;
    a2 = req_valid_2 && n <= DEPTH - 2 && !flush_valid;
    ov = (req_valid_1 && n == DEPTH) || (req_valid_2 && n > DEPTH - 2);
    n1 = '{mt, req_lreg_1, req_preg_1, req_ppreg_1, 0, 0};
    n2 = '{(mt + 1) % DEPTH, req_lreg_2, req_preg_2, req_ppreg_2, 0, 0};
    w1 = wb_valid_1; t1 = wb_ticket_1; w2 = wb_valid_2; t2 = wb_ticket_2;
    f = flush_valid; ft = flush_ticket;
    @(posedge clk);
    if (w1) mark_done(t1);
    if (w2) mark_done(t2);
    if (f) mark_flush(ft);
    if (a1) mq.push_back(n1);
    if (a2) mq.push_back(n2);
    mt = (mt + int'(a1) + int'(a2)) % DEPTH;
    if (ov) movf = 1;
    #1;
    req_valid_1 = 0; req_valid_2 = 0; wb_valid_1 = 0; wb_valid_2 = 0; flush_valid = 0;
  endtask

  task automatic rnd_payload();
    req_lreg_1 = LW'($urandom); req_lreg_2 = LW'($urandom);
    req_preg_1 = PW'($urandom); req_preg_2 = PW'($urandom);
    req_ppreg_1 = PW'($urandom); req_ppreg_2 = PW'($urandom);
  endtask

  task automatic drive(bit r1, bit r2, bit w1, int t1, bit w2, int t2, bit f, int ft);
    req_valid_1 = r1; req_valid_2 = r2;
    wb_valid_1 = w1; wb_ticket_1 = RIB'(t1);
    wb_valid_2 = w2; wb_ticket_2 = RIB'(t2);
    flush_valid = f; flush_ticket = RIB'(ft);
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rst = 1;
    mq.delete(); mt = 0; movf = 0;
    #1;
    chk("rst_commit_valid_1", commit_valid_1, 0);
    chk("rst_commit_valid_2", commit_valid_2, 0);
    chk("rst_ticket", ticket, 0);
    chk("rst_is_full", is_full, 0);
    chk("rst_two_empty", two_empty, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Dual alloc with known payload, then writeback both.
    req_lreg_1 = 3; req_lreg_2 = 4; req_preg_1 = 33; req_preg_2 = 34;
    req_ppreg_1 = 3; req_ppreg_2 = 4;
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    chk("dual_alloc_ticket", ticket, 2);
    drive(0, 0, 1, 0, 1, 1, 0, 0);
    idle(2);

    // Fill to full one at a time, then an overflowing request.
    do_reset();
    for (int i = 0; i < 9; i++) begin rnd_payload(); drive(1, 0, 0, 0, 0, 0, 0, 0); end
    chk("overflow_sticky", overflow_err, 1);
    // Dual commit from a full buffer while a request is dropped.
    drive(0, 0, 1, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("after_full_commit_two_empty", two_empty, 1);
    for (int i = 2; i < 8; i += 2) drive(0, 0, 1, i, 1, i + 1, 0, 0);
    idle(3);

    // Branch flush: tickets 2..4 are wrong path.
    do_reset();
    rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0);
    rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0);
    rnd_payload(); drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 1, 1, 0, 0);
    idle(4);

    // Wraparound: retire six, then allocate 6,7,0.
    do_reset();
    for (int i = 0; i < 3; i++) begin rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0); end
    for (int i = 0; i < 6; i += 2) drive(0, 0, 1, i, 1, i + 1, 0, 0);
    idle(3);
    rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0);
    rnd_payload(); drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_ticket", ticket, 1);
    drive(0, 0, 1, 6, 1, 7, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Reset while entries are retiring.
    do_reset();
    rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0);
    rnd_payload(); drive(1, 1, 0, 0, 0, 0, 0, 0);
    rnd_payload(); drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 2, 1, 3, 0, 0);
    do_reset();
    idle(2);

    // Random traffic, with one reset partway to clear the sticky overflow.
    for (int c = 0; c < 800; c++) begin
      bit r1, r2, w1, w2, f;
      int t1, t2, ft;
      if (c == 400) do_reset();
      rnd_payload();
      r1 = ($urandom % 10) < 7;
      r2 = r1 && ($urandom % 2);
      w1 = ($urandom % 10) < 6;
      w2 = ($urandom % 10) < 4;
      t1 = $urandom % DEPTH; t2 = $urandom % DEPTH; ft = 0;
      if (mq.size() > 0 && ($urandom % 4) != 0) t1 = mq[$urandom % mq.size()].tk;
      if (mq.size() > 0 && ($urandom % 4) != 0) t2 = mq[$urandom % mq.size()].tk;
      f = mq.size() > 0 && ($urandom % 16) == 0;
      if (f) ft = mq[$urandom % mq.size()].tk;
      drive(r1, r2, w1, t1, w2, t2, f, ft);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_commit_queue.md
ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

Interface
REQ-001 Parameter ROB_INDEX_BITS, default 3, ticket width; depth DEPTH = 2**ROB_INDEX_BITS.
REQ-002 Parameter P_ADDR_WIDTH, default 5, physical register index width.
REQ-003 Parameter L_ADDR_WIDTH, default 5, logical register index width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid_1/req_valid_2  in  1 each  allocation requests, slot 1 older; req_valid_2 only asserted with req_valid_1.
REQ-007 req_lreg_1/2  in  L_ADDR_WIDTH  logical destination; req_preg_1/2, req_ppreg_1/2  in  P_ADDR_WIDTH  new and previous physical destination.
REQ-008 ticket  out  ROB_INDEX_BITS  tail index; slot 1 gets ticket, slot 2 gets ticket+1 (mod DEPTH).
REQ-009 is_full  out  1  count == DEPTH; two_empty  out  1  count <= DEPTH-2.
REQ-010 wb_valid_1/wb_valid_2  in  1 each; wb_ticket_1/2  in  ROB_INDEX_BITS  execution-complete marks.
REQ-011 flush_valid  in  1; flush_ticket  in  ROB_INDEX_BITS  mispredicted branch ticket.
REQ-012 commit_valid_1/2  out  1; commit_ldst_1/2  out  L_ADDR_WIDTH; commit_pdst_1/2, commit_ppdst_1/2  out  P_ADDR_WIDTH; commit_flushed_1/2  out  1.

Function
REQ-013 Circular buffer: per-entry valid, done, flushed, lreg, preg, ppreg; head, tail pointers ROB_INDEX_BITS wide, wrapping mod DEPTH; count 0..DEPTH.
REQ-014 Allocate slot 1 when req_valid_1 & ~is_full & ~flush_valid; slot 2 when req_valid_2 & two_empty & ~flush_valid; tail advances by number allocated.
REQ-015 Requests lacking space (req_valid_1 & is_full, req_valid_2 & ~two_empty) are dropped, state unchanged; sticky overflow_err out 1 sets, cleared only by reset.
REQ-016 New entry written valid=1, done=0, flushed=0.
REQ-017 wb_valid_n sets done of entry wb_ticket_n next cycle; writeback to invalid entry ignored; both ports same ticket legal.
REQ-018 Age of index i = (i - head) mod DEPTH; entry younger than X iff age(i) > age(X).
REQ-019 flush_valid: every valid entry younger than flush_ticket gets flushed=1 next edge; flush_ticket entry and older unaffected; tail not rolled back.
REQ-020 flush_valid suppresses allocation that cycle (flush priority over allocation).
REQ-021 Entry retirable when valid & (done | flushed).
REQ-022 commit_valid_1 = head entry retirable; commit_valid_2 = commit_valid_1 & entry head+1 retirable; combinational from registered state, zero-cycle latency.
REQ-023 commit fields driven from head / head+1 entries; commit_flushed = entry flushed bit; all commit fields 0 when corresponding commit_valid 0.
REQ-024 Committed entries cleared (valid=0) and head advances by commits issued, same edge.
REQ-025 Simultaneous alloc and commit: count_next = count + allocs - commits; full buffer with commit frees space only from next cycle (is_full uses registered count).
REQ-026 Flush same cycle as commit: commit uses pre-edge state; flushed marks apply to entries still valid after the edge.
REQ-027 Writeback and flush on same entry same cycle: both bits set.
REQ-028 Ticket wrap: ticket+1 from DEPTH-1 yields 0.

Reset
REQ-029 rst asserted: head=tail=0, count=0, all valid/done/flushed=0, overflow_err=0, asynchronously.
REQ-030 Outputs during/after reset: ticket=0, is_full=0, two_empty=1, all commit_* = 0.
REQ-031 Reset mid-operation discards all entries; no commits emitted for them.

Verification
REQ-032 Reset, dual alloc lreg 3/4 preg 33/34 ppreg 3/4 -> ticket 0 then 2; wb tickets 0,1 -> next cycle commit_valid_1/2=1, ldst 3/4, ppdst 3/4, flushed 0.
REQ-033 Fill 8 single allocs -> is_full=1, two_empty=0 after 7th/8th; 9th request dropped, overflow_err=1, ticket unchanged.
REQ-034 Alloc tickets 0..4, flush_ticket=1 -> tickets 2,3,4 flushed; wb 0,1 -> commits 0,1 flushed 0, then 2,3 flushed 1 (pdst reported), then 4 flushed 1.
REQ-035 head=6 with entries 6,7,0 done -> commits 6,7 then 0; ticket wraps 7->0; count correct.
REQ-036 Full buffer, dual commit and req_valid_1 same cycle -> request dropped, count 6 next cycle, two_empty=1.
REQ-037 rst asserted with 5 valid entries mid-commit -> all commit_valid 0 immediately, count 0, ticket 0.
